assoc_cache: RTL and testbench

ASSOC_CACHE -- requirements
Module: assoc_cache

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_lru.sv | 51 +++++
 rtl/assoc_cache.sv | 184 ++++++++++++++++++
 tb/tb_assoc_cache.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache.
//   state_e : controller FSM states
//   idx_w / tag_w / age_w : widths derived from the cache geometry, so the
//   top and the replacement logic size their fields the same way.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    FILL_REQ  = 3'd2,
    FILL_WAIT = 3'd3,
    WR_REQ    = 3'd4,
    RESP      = 3'd5
  } state_e;

  // Set index bits sit directly above the two byte-offset bits.
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - $clog2(sets) - 2;
  endfunction

  // One age value per way; ages of a set form a permutation of 0..ways-1.
  function automatic int age_w(input int ways);
    return $clog2(ways);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Replacement logic for one cache set (purely combinational).
// Ports:
//   age_i        current ages of the set's ways (0 = most recently used)
//   valid_i      valid bits of the set's ways
//   hit_way_i    way being touched on a hit
//   use_victim_i 1: the touched way is the victim (fill); 0: hit_way_i
//   age_o        ages after touching the selected way
//   victim_o     lowest-index invalid way, else the way with the oldest age
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS = 2
) (
  input  logic [WAYS-1:0][$clog2(WAYS)-1:0] age_i,
  input  logic [WAYS-1:0]                   valid_i,
  input  logic [$clog2(WAYS)-1:0]           hit_way_i,
  input  logic                              use_victim_i,
  output logic [WAYS-1:0][$clog2(WAYS)-1:0] age_o,
  output logic [$clog2(WAYS)-1:0]           victim_o
);

  localparam int AGE_W = age_w(WAYS);
  localparam int WAY_W = $clog2(WAYS);

  logic [WAY_W-1:0] touch_way;

  // Oldest way first, then let any invalid way override it; scanning from
  // the top down leaves the lowest-index invalid way as the final choice.
  always_comb begin
    victim_o = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (age_i[i] == AGE_W'(WAYS - 1)) victim_o = WAY_W'(i);
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_i[i]) victim_o = WAY_W'(i);
    end
  end

  assign touch_way = use_victim_i ? victim_o : hit_way_i;

  // Touched way becomes youngest; only ways younger than it age by one,
  // which keeps the ages a permutation.
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      if (WAY_W'(i) == touch_way)                 age_o[i] = '0;
      else if (age_i[i] < age_i[touch_way])       age_o[i] = age_i[i] + AGE_W'(1);
      else                                        age_o[i] = age_i[i];
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Write-through, no-write-allocate set-associative cache with LRU replacement.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   req_*               request: req_valid/req_ready handshake, addr, we, wdata
//   resp_*              one-cycle resp_valid pulse; resp_data/resp_hit held
//   mem_req_*           backing-store request: valid/ready handshake, we, addr, wdata
//   mem_resp_*          backing-store read return (used only while filling)
//   dbg_state           current controller state
// Handshake rule (both request channels): a transfer happens on a rising
// edge where valid && ready; the source holds valid and payload stable
// until that edge.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 2,
  parameter int SETS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output state_e            dbg_state
);

  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS);
  localparam int AGE_W = age_w(WAYS);
  localparam int WAY_W = $clog2(WAYS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                hit_q;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_hit_q, resp_hit_d;

  logic [WAYS-1:0]              valid_q [SETS];
  logic [WAYS-1:0][AGE_W-1:0]   age_q   [SETS];
  logic [TAG_W-1:0]             tag_q   [SETS][WAYS];
  logic [DATA_W-1:0]            data_q  [SETS][WAYS];

  logic [IDX_W-1:0]           idx;
  logic [TAG_W-1:0]           tag;
  logic                       hit;
  logic [WAY_W-1:0]           hit_way;
  logic [WAY_W-1:0]           victim;
  logic [WAYS-1:0][AGE_W-1:0] age_next;
  logic                       hit_upd, fill_upd, wr_hit_upd;

  assign idx = addr_q[IDX_W+1:2];
  assign tag = addr_q[ADDR_W-1:IDX_W+2];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  cache_lru #(.WAYS(WAYS)) u_lru (
    .age_i        (age_q[idx]),
    .valid_i      (valid_q[idx]),
    .hit_way_i    (hit_way),
    .use_victim_i (state_q == FILL_WAIT),
    .age_o        (age_next),
    .victim_o     (victim)
  );

  always_comb begin
    state_d     = state_q;
    resp_data_d = resp_data_q;
    resp_hit_d  = resp_hit_q;
    hit_upd     = 1'b0;
    fill_upd    = 1'b0;
    wr_hit_upd  = 1'b0;
    case (state_q)
      IDLE:      if (req_valid) state_d = LOOKUP;
      LOOKUP: begin
        if (we_q) begin
          state_d    = WR_REQ;
          hit_upd    = hit;
          wr_hit_upd = hit;
        end else if (hit) begin
          state_d     = RESP;
          resp_data_d = data_q[idx][hit_way];
          resp_hit_d  = 1'b1;
          hit_upd     = 1'b1;
        end else begin
          state_d = FILL_REQ;
        end
      end
      FILL_REQ:  if (mem_req_ready) state_d = FILL_WAIT;
      FILL_WAIT: if (mem_resp_valid) begin
        state_d     = RESP;
        resp_data_d = mem_resp_data;
        resp_hit_d  = 1'b0;
        fill_upd    = 1'b1;
      end
      WR_REQ:    if (mem_req_ready) begin
        state_d     = RESP;
        resp_data_d = wdata_q;
        resp_hit_d  = hit_q;
      end
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      hit_q       <= 1'b0;
      resp_data_q <= '0;
      resp_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      resp_hit_q  <= resp_hit_d;
      if (state_q == LOOKUP) hit_q <= hit;
      if (req_valid && req_ready) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
      end
    end else begin
      if (hit_upd || fill_upd) age_q[idx] <= age_next;
      if (fill_upd) valid_q[idx][victim] <= 1'b1;
    end
  end

  // Tag/data contents are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (fill_upd) begin
      tag_q[idx][victim]  <= tag;
      data_q[idx][victim] <= mem_resp_data;
    end else if (wr_hit_upd) begin
      data_q[idx][hit_way] <= wdata_q;
    end
  end

  // Gating with rst keeps the handshake outputs low while reset is held.
  assign req_ready     = rst && (state_q == IDLE);
  assign resp_valid    = rst && (state_q == RESP);
  assign resp_data     = resp_data_q;
  assign resp_hit      = resp_hit_q;
  assign mem_req_valid = rst && ((state_q == FILL_REQ) || (state_q == WR_REQ));
  assign mem_req_we    = rst && (state_q == WR_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_assoc_cache.sv
// Self-checking bench for assoc_cache (WAYS=2, SETS=4).
// Reference model: per set, a recency-ordered list of resident tags (front =
// most recent, at most WAYS entries) plus a word-addressed backing memory.
module tb_assoc_cache;
  import cache_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WAYS   = 2;
  localparam int SETS   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid, resp_hit;
  logic [DATA_W-1:0] resp_data;
  logic              mem_req_valid, mem_req_ready, mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  state_e            dbg_state;

  assoc_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];      // {is_write, hit, read_data}
  int          exp_dl_q[$];   // required response cycle, 0 = any
  logic [64:0] exp_mem_q[$];  // {we, addr, wdata}

  logic [27:0] lru_q[SETS][$];
  logic [31:0] mem_m[int];

  bit auto_resp = 1'b1;
  bit force_ready_low = 1'b0;
  int inject_req = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int k;
    k = int'(a >> 2);
    if (mem_m.exists(k)) return mem_m[k];
    return (a & 32'hFFFF_FFFC) ^ 32'hA5A5_0000;
  endfunction

  // Returns hit and updates recency; read misses allocate, write misses do not.
  function automatic bit model_access(input logic [31:0] a, input bit we);
    int s;
    logic [27:0] t;
    int pos;
    s = int'(a[3:2]);
    t = a[31:4];
    pos = -1;
    for (int i = 0; i < lru_q[s].size(); i++) if (lru_q[s][i] == t) pos = i;
    if (pos >= 0) begin
      lru_q[s].delete(pos);
      lru_q[s].push_front(t);
      return 1'b1;
    end
    if (!we) begin
      lru_q[s].push_front(t);
      if (lru_q[s].size() > WAYS) void'(lru_q[s].pop_back());
    end
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd);
    bit hit;
    int n;
    int acc;
    logic [31:0] rd;
    rd  = mem_rd(a);
    hit = model_access(a, we);
    if (we) begin
      exp_mem_q.push_back({1'b1, a, wd});
      mem_m[int'(a >> 2)] = wd;
    end else if (!hit) begin
      exp_mem_q.push_back({1'b0, a, 32'h0});
    end
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_accept", req_ready, 1'b1);
    if (!req_ready) begin
      req_valid = 1'b0;
      exp_mem_q.delete();
      return;
    end
    acc = cyc;
    exp_q.push_back({we, hit, rd});
    exp_dl_q.push_back((!we && hit) ? acc + 2 : 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_mem_q.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("txn_done_in_budget", (n < 200), 1'b1);
    if (n >= 200) begin exp_q.delete(); exp_dl_q.delete(); exp_mem_q.delete(); end
    @(negedge clk);
  endtask

  // ---------------- backing memory responder ----------------
  initial begin
    bit fill_pending;
    int countdown;
    int inject_done;
    logic [31:0] pend_addr;
    logic [64:0] e;
    fill_pending = 0; countdown = 0; inject_done = 0; pend_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_rd(pend_addr);
          fill_pending   = 0;
        end
      end else if (inject_done != inject_req) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        inject_done    = inject_req;
      end else if (!fill_pending && auto_resp && $urandom_range(0, 7) == 0) begin
        // stray return while not filling must be ignored
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
      end
      mem_req_ready = force_ready_low ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (mem_req_valid && mem_req_ready) begin
        if (exp_mem_q.size() == 0) begin
          chk("mem_req_unexpected", mem_req_valid, 1'b0);
        end else begin
          e = exp_mem_q.pop_front();
          chk("mem_req_we", mem_req_we, e[64]);
          chk("mem_req_addr", mem_req_addr, e[63:32]);
          if (e[64]) chk("mem_req_wdata", mem_req_wdata, e[31:0]);
          else if (auto_resp) begin
            fill_pending = 1;
            pend_addr    = mem_req_addr;
            countdown    = $urandom_range(1, 3);
          end
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    int dl;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", resp_valid, 1'b0);
      end else begin
        e  = exp_q.pop_front();
        dl = exp_dl_q.pop_front();
        chk("resp_hit", resp_hit, e[32]);
        if (!e[33]) chk("resp_data", resp_data, e[31:0]);
        if (dl != 0) chk("hit_latency", cyc, dl);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    mem_m[int'(32'h40 >> 2)] = 32'hDEAD_BEEF;

    // reset values
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_hit", resp_hit, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_mem_req_we", mem_req_we, 1'b0);
    rst = 1'b1;
    #1;
    chk("post_rst_req_ready", req_ready, 1'b1);

    // set-0 LRU eviction: 0x20 evicts 0x10
    issue(32'h00, 0, 0); wait_idle();
    issue(32'h10, 0, 0); wait_idle();
    issue(32'h00, 0, 0); wait_idle();
    issue(32'h20, 0, 0); wait_idle();
    issue(32'h00, 0, 0); wait_idle();
    issue(32'h10, 0, 0); wait_idle();

    // cold read then hit of 0x40
    issue(32'h40, 0, 0); wait_idle();
    issue(32'h40, 0, 0); wait_idle();

    // write hit, read back, write miss (no allocate)
    issue(32'h40, 1, 32'h1234); wait_idle();
    issue(32'h40, 0, 0);        wait_idle();
    issue(32'h80, 1, 32'h5678); wait_idle();
    issue(32'h80, 0, 0);        wait_idle();

    // backpressure in FILL_REQ
    force_ready_low = 1'b1;
    issue(32'h1C, 0, 0);
    n = 0;
    while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
    chk("stall_reached", mem_req_valid, 1'b1);
    repeat (5) begin
      chk("stall_mem_req_valid", mem_req_valid, 1'b1);
      chk("stall_mem_req_addr", mem_req_addr, 32'h1C);
      chk("stall_mem_req_we", mem_req_we, 1'b0);
      chk("stall_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    force_ready_low = 1'b0;
    wait_idle();

    // reset while waiting for a fill; 0x04 hit beforehand
    issue(32'h04, 0, 0); wait_idle();
    issue(32'h04, 0, 0); wait_idle();
    auto_resp = 1'b0;
    issue(32'h38, 0, 0);
    n = 0;
    while (exp_mem_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("in_fill_wait", dbg_state, FILL_WAIT);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); exp_dl_q.delete(); exp_mem_q.delete();
    for (int s = 0; s < SETS; s++) lru_q[s].delete();
    inject_req++;
    repeat (6) begin
      @(negedge clk);
      chk("rst_abandon_no_resp", resp_valid, 1'b0);
    end
    auto_resp = 1'b1;
    issue(32'h04, 0, 0); wait_idle();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic we;
      a  = 32'(($urandom_range(0, 5) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      we = ($urandom_range(0, 2) == 0);
      issue(a, we, $urandom);
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: sim time %0t exceeded budget", $time);
    $fatal(1, "timeout");
  end

endmodule
